// File: rtl/host_vram_write_queue.sv
// rtl/host_vram_write_queue.sv - posted host write FIFO that drains to VRAM only during vblank
//
// Ports:
//   pixel_clk, reset        sole clock; synchronous active-high reset
//   host_cs/addr/wdata      host write request, held until host_done
//   host_done               write accepted; high until host_cs is sampled low
//   host_write_avail        queue not full (registers only, no host_cs path)
//   vblank                  drain enable from video timing
//   vram_cs/we/addr/wdata   VRAM write access, held until vram_done
//   vram_done               VRAM completion strobe
//   queue_level             occupied entry count
module host_vram_write_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic                       pixel_clk,
    input  logic                       reset,
    input  logic                       host_cs,
    input  logic [ADDR_W-1:0]          host_addr,
    input  logic [DATA_W-1:0]          host_wdata,
    output logic                       host_done,
    output logic                       host_write_avail,
    input  logic                       vblank,
    output logic                       vram_cs,
    output logic                       vram_we,
    output logic [ADDR_W-1:0]          vram_addr,
    output logic [DATA_W-1:0]          vram_wdata,
    input  logic                       vram_done,
    output logic [$clog2(DEPTH+1)-1:0] queue_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic {H_IDLE, H_ACK}    h_state_t;
    typedef enum logic {D_IDLE, D_ACCESS} d_state_t;

    h_state_t           h_state, h_next;
    d_state_t           d_state, d_next;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] rd_entry;
    logic               push, pop, full, empty;

    // Both decodes use the pre-edge level, so a same-cycle pop never frees
    // room for a push, and a freshly pushed entry is invisible to the drain
    // side until the following edge.
    assign full             = (queue_level == LVL_W'(DEPTH));
    assign empty            = (queue_level == '0);
    assign host_write_avail = !full;
    assign host_done        = (h_state == H_ACK);
    assign vram_cs          = (d_state == D_ACCESS);
    assign vram_we          = vram_cs;
    assign rd_entry         = mem[rd_ptr];

    always_comb begin
        h_next = h_state;
        push   = 1'b0;
        case (h_state)
            H_IDLE: begin
                if (host_cs && !full) begin
                    push   = 1'b1;
                    h_next = H_ACK;
                end
            end
            H_ACK: begin
                // Host must drop cs for one sampled edge before the next write.
                if (!host_cs) begin
                    h_next = H_IDLE;
                end
            end
            default: h_next = H_IDLE;
        endcase
    end

    always_comb begin
        d_next = d_state;
        pop    = 1'b0;
        case (d_state)
            D_IDLE: begin
                if (vblank && !empty) begin
                    pop    = 1'b1;
                    d_next = D_ACCESS;
                end
            end
            D_ACCESS: begin
                // An access in flight finishes even if vblank has dropped.
                if (vram_done) begin
                    d_next = D_IDLE;
                end
            end
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_state     <= H_IDLE;
            d_state     <= D_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_level <= '0;
            vram_addr   <= '0;
            vram_wdata  <= '0;
        end else begin
            h_state <= h_next;
            d_state <= d_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                vram_addr  <= rd_entry[ENTRY_W-1:DATA_W];
                vram_wdata <= rd_entry[DATA_W-1:0];
            end
            case ({push, pop})
                2'b10:   queue_level <= queue_level + LVL_W'(1);
                2'b01:   queue_level <= queue_level - LVL_W'(1);
                default: queue_level <= queue_level;
            endcase
        end
    end

    // Storage needs no reset: discarded entries are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge pixel_clk) begin
        if (push) begin
            mem[wr_ptr] <= {host_addr, host_wdata};
        end
    end

endmodule
